regfile_port_arbiter: RTL and testbench
=======================================

Name: regfile_port_arbiter

Overview:
- Shares the single register-file port set (one write port, read ports A/B) between the processor core and a test/debug requester.
- Normally the core owns the regfile.
- On a test request, the arbiter stalls the core, drains in-flight writebacks for a fixed window, then grants the test side a valid/ready read/write channel.
- On release, ownership returns to the core.

Parameters:
- ADDR_W, 5, register index width (32 registers).
- DATA_W, 32, register data width.
- DRAIN_CYCLES, 4, cycles core writebacks may still retire after stall assertion before test grant.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- core_we  in  1  core write enable.
- core_wreg  in  ADDR_W  core write index.
- core_wdata  in  DATA_W  core write data.
- core_rregA  in  ADDR_W  core read index A.
- core_rregB  in  ADDR_W  core read index B.
- core_rdataA  out  DATA_W  read data A to core (pass-through of rf_rdataA).
- core_rdataB  out  DATA_W  read data B to core (pass-through of rf_rdataB).
- core_stall  out  1  core must hold its pipeline.
- tst_req  in  1  test side requests ownership (level).
- tst_gnt  out  1  test side owns regfile.
- tst_valid  in  1  test op valid.
- tst_ready  out  1  arbiter accepts test op.
- tst_we  in  1  1 = write op, 0 = read op.
- tst_reg  in  ADDR_W  test op register index.
- tst_wdata  in  DATA_W  test write data.
- tst_rvalid  out  1  read data valid pulse.
- tst_rdata  out  DATA_W  registered read data.
- rf_we  out  1  regfile write enable.
- rf_wreg  out  ADDR_W  regfile write index.
- rf_wdata  out  DATA_W  regfile write data.
- rf_rregA  out  ADDR_W  regfile read index A.
- rf_rregB  out  ADDR_W  regfile read index B.
- rf_rdataA  in  DATA_W  regfile read data A (combinational read).
- rf_rdataB  in  DATA_W  regfile read data B.

Behaviour:

Reset (reset low, asynchronous):
- state = CORE, drain counter = 0.
- tst_gnt = 0, tst_rvalid = 0, tst_rdata = 0.
- core_stall = 0; rf_* follow core inputs.

State CORE:
- rf_* driven combinationally from core_*. core_stall = 0, tst_ready = 0.
- tst_req = 1 moves to DRAIN and loads the counter with max(DRAIN_CYCLES, 1).

State DRAIN:
- core_stall = 1. core writes still pass to rf_we/rf_wreg/rf_wdata so in-flight writebacks retire.
- Counter decrements each cycle; on the cycle it reaches 0, move to TEST.
- tst_req = 0 during DRAIN returns to CORE next cycle and clears the counter.

State TEST:
- tst_gnt = 1 (registered, asserted the first cycle in TEST). core_stall = 1. core_we ignored.
- tst_ready = tst_req.
- Accept = tst_valid & tst_ready.
- Write accept: rf_we = 1, rf_wreg = tst_reg, rf_wdata = tst_wdata in the same cycle.
- Read accept: rf_rregA = tst_reg in the same cycle. tst_rdata <= rf_rdataA at the edge; tst_rvalid pulses for exactly 1 cycle, 1 cycle after accept.
- Back-to-back accepts allowed every cycle.
- rf_we = 0 when no write is accepted. rf_rregB = core_rregB.
- tst_req = 0: tst_ready = 0 that cycle, move to CORE next cycle, tst_gnt drops with the state change. A read accepted on the last TEST cycle still returns its tst_rvalid.

General rules:
- tst_valid outside TEST is ignored; no response.
- core_rdataA/B = rf_rdataA/B at all times; meaningful only while core_stall = 0.
- Reset asserted mid-TEST or mid-DRAIN: immediate return to CORE; outputs take their reset values with no clock needed.

Optional Feature:
REGFILE_ARB_R0_PROTECT_EN
- Defined: a test write with tst_reg = 0 is accepted (tst_ready honoured) but rf_we stays 0. Output tst_err (1 bit, registered) pulses 1 cycle after that accept. tst_err resets to 0.
- Undefined: no tst_err port; writes to index 0 go to the regfile unchanged (regfile is responsible for r0 hardwiring).

Test Plan:
- Reset/idle: reset low then high, core_we = 1, wreg = 3, wdata = 0xA5 -> rf_we = 1, rf_wreg = 3, rf_wdata = 0xA5 same cycle; core_stall = 0, tst_gnt = 0.
- Drain: tst_req rises at cycle N with DRAIN_CYCLES = 4 -> core_stall = 1 from N+1; core write of r5 = 7 at N+2 reaches rf; tst_gnt = 1 at N+5.
- Test write/read: in TEST write r1 = 65535, next cycle read r1 -> rf_we pulse with wreg = 1; tst_rvalid 1 cycle after the read accept with tst_rdata = 65535.
- Core lockout: in TEST, core_we = 1, wreg = 2, wdata = 9 -> rf_we = 0; a later read of r2 returns its prior value.
- Abort: tst_req drops during DRAIN at counter = 2 -> CORE next cycle, core_stall = 0, tst_gnt never asserted.
- Async reset mid-TEST: reset low between clock edges -> tst_gnt = 0, core_stall = 0 immediately; with REGFILE_ARB_R0_PROTECT_EN defined, a write to r0 gives rf_we = 0 and a tst_err pulse.

Source files
------------

// File: rtl/regfile_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_port_arbiter_if
//
// Purpose:
//   Test/debug side channel of the register-file port arbiter. It bundles the
//   ownership handshake (tst_req/tst_gnt) and the valid/ready operation
//   channel (tst_valid/tst_ready plus op fields) together with the read
//   response (tst_rvalid/tst_rdata).
//
// Signals:
//   tst_req     requester -> arbiter  ownership request (level)
//   tst_gnt     arbiter -> requester  requester currently owns the regfile
//   tst_valid   requester -> arbiter  operation valid
//   tst_ready   arbiter -> requester  operation accepted this cycle
//   tst_we      requester -> arbiter  1 = write, 0 = read
//   tst_reg     requester -> arbiter  register index
//   tst_wdata   requester -> arbiter  write data
//   tst_rvalid  arbiter -> requester  read data valid (1-cycle pulse)
//   tst_rdata   arbiter -> requester  registered read data
//   tst_err     arbiter -> requester  r0 write rejected (1-cycle pulse),
//                                     present only with REGFILE_ARB_R0_PROTECT_EN
//
// Modports:
//   master  the test/debug requester
//   slave   the arbiter
//
// Optional feature macro: REGFILE_ARB_R0_PROTECT_EN
// ---------------------------------------------------------------------------
interface regfile_port_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);

  logic              tst_req;
  logic              tst_gnt;
  logic              tst_valid;
  logic              tst_ready;
  logic              tst_we;
  logic [ADDR_W-1:0] tst_reg;
  logic [DATA_W-1:0] tst_wdata;
  logic              tst_rvalid;
  logic [DATA_W-1:0] tst_rdata;
`ifdef REGFILE_ARB_R0_PROTECT_EN
  logic              tst_err;
`endif

`ifdef REGFILE_ARB_R0_PROTECT_EN
  modport master (
    output tst_req, tst_valid, tst_we, tst_reg, tst_wdata,
    input  tst_gnt, tst_ready, tst_rvalid, tst_rdata, tst_err
  );

  modport slave (
    input  tst_req, tst_valid, tst_we, tst_reg, tst_wdata,
    output tst_gnt, tst_ready, tst_rvalid, tst_rdata, tst_err
  );
`else
  modport master (
    output tst_req, tst_valid, tst_we, tst_reg, tst_wdata,
    input  tst_gnt, tst_ready, tst_rvalid, tst_rdata
  );

  modport slave (
    input  tst_req, tst_valid, tst_we, tst_reg, tst_wdata,
    output tst_gnt, tst_ready, tst_rvalid, tst_rdata
  );
`endif

endinterface

// File: rtl/regfile_port_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_port_arbiter
//
// Purpose:
//   Shares one register-file port set (one write port, read ports A/B)
//   between the processor core and a test/debug requester. The core owns the
//   regfile by default. When the test side requests ownership the core is
//   stalled, in-flight core writebacks are allowed to retire for a fixed drain
//   window, and then the test side gets a valid/ready read/write channel.
//   Dropping the request hands the regfile back to the core.
//
// Parameters:
//   ADDR_W        register index width
//   DATA_W        register data width
//   DRAIN_CYCLES  cycles core writebacks may retire after stall, before grant
//                 (a value of 0 behaves as 1)
//
// Ports:
//   clock                 system clock, rising edge
//   reset                 asynchronous reset, active low
//   core_we/wreg/wdata    core write port
//   core_rregA/B          core read indices
//   core_rdataA/B         read data to the core (pass-through of rf_rdataA/B)
//   core_stall            core must hold its pipeline
//   tst                   test/debug channel (regfile_port_arbiter_if.slave)
//   rf_we/wreg/wdata      regfile write port
//   rf_rregA/B            regfile read indices
//   rf_rdataA/B           regfile combinational read data
//
// Optional feature macro: REGFILE_ARB_R0_PROTECT_EN
//   When defined, test writes to register 0 are accepted but dropped, and
//   tst.tst_err pulses one cycle after such an accept.
// ---------------------------------------------------------------------------
module regfile_port_arbiter #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  core_we,
  input  logic [ADDR_W-1:0]     core_wreg,
  input  logic [DATA_W-1:0]     core_wdata,
  input  logic [ADDR_W-1:0]     core_rregA,
  input  logic [ADDR_W-1:0]     core_rregB,
  output logic [DATA_W-1:0]     core_rdataA,
  output logic [DATA_W-1:0]     core_rdataB,
  output logic                  core_stall,

  regfile_port_arbiter_if.slave tst,

  output logic                  rf_we,
  output logic [ADDR_W-1:0]     rf_wreg,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic [ADDR_W-1:0]     rf_rregA,
  output logic [ADDR_W-1:0]     rf_rregB,
  input  logic [DATA_W-1:0]     rf_rdataA,
  input  logic [DATA_W-1:0]     rf_rdataB
);

  // A zero-length drain window still spends one cycle in DRAIN so the stall
  // is always visible to the core before the test side takes over.
  localparam int DRAIN_LOAD = (DRAIN_CYCLES < 1) ? 1 : DRAIN_CYCLES;
  localparam int CNT_W      = $clog2(DRAIN_LOAD + 1);

  typedef enum logic [1:0] {
    CORE  = 2'd0,
    DRAIN = 2'd1,
    TEST  = 2'd2
  } arbState_t;

  arbState_t         state_q, state_d;
  logic [CNT_W-1:0]  drainCnt_q, drainCnt_d;
  logic              gnt_q;
  logic              stall_q;
  logic              rdValid_q;
  logic [DATA_W-1:0] rdData_q;

  logic              inTest;
  logic              tstReady;
  logic              accept;
  logic              wrAccept;
  logic              rdAccept;
  logic              wrCommit;

  // Next-state logic for ownership. The drain counter is loaded on leaving
  // CORE and the hand-over to TEST happens on the edge where it reaches 0,
  // giving exactly DRAIN_LOAD cycles of DRAIN.
  always_comb begin
    state_d    = state_q;
    drainCnt_d = drainCnt_q;
    unique case (state_q)
      CORE: begin
        if (tst.tst_req) begin
          state_d    = DRAIN;
          drainCnt_d = CNT_W'(DRAIN_LOAD);
        end
      end
      DRAIN: begin
        if (!tst.tst_req) begin
          state_d    = CORE;
          drainCnt_d = '0;
        end else if (drainCnt_q <= CNT_W'(1)) begin
          state_d    = TEST;
          drainCnt_d = '0;
        end else begin
          drainCnt_d = drainCnt_q - CNT_W'(1);
        end
      end
      TEST: begin
        if (!tst.tst_req) begin
          state_d = CORE;
        end
      end
      default: begin
        state_d    = CORE;
        drainCnt_d = '0;
      end
    endcase
  end

  // Ownership FSM registers. Grant and stall are registered from the next
  // state so they change on the same edge as the state itself.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= CORE;
      drainCnt_q <= '0;
      gnt_q      <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      drainCnt_q <= drainCnt_d;
      gnt_q      <= (state_d == TEST);
      stall_q    <= (state_d != CORE);
    end
  end

  // Test channel handshake. Ready follows the request level only while the
  // test side owns the port, so a dropped request refuses ops immediately.
  assign inTest   = (state_q == TEST);
  assign tstReady = inTest & tst.tst_req;
  assign accept   = tst.tst_valid & tstReady;
  assign wrAccept = accept & tst.tst_we;
  assign rdAccept = accept & ~tst.tst_we;

`ifdef REGFILE_ARB_R0_PROTECT_EN
  logic r0Hit;
  logic err_q;

  // Writes to r0 complete the handshake but never reach the regfile.
  assign r0Hit    = wrAccept & (tst.tst_reg == '0);
  assign wrCommit = wrAccept & ~r0Hit;
`else
  assign wrCommit = wrAccept;
`endif

  // Regfile port mux. The core drives everything outside TEST, including
  // during DRAIN so writebacks already in the pipe still land. In TEST the
  // write port and read port A belong to the test side; port B stays with
  // the core since the test channel only ever reads through port A.
  always_comb begin
    rf_we    = core_we;
    rf_wreg  = core_wreg;
    rf_wdata = core_wdata;
    rf_rregA = core_rregA;
    rf_rregB = core_rregB;
    if (inTest) begin
      rf_we    = wrCommit;
      rf_wreg  = tst.tst_reg;
      rf_wdata = tst.tst_wdata;
      rf_rregA = tst.tst_reg;
    end
  end

  // Read response: capture port A on the accept edge and pulse valid for one
  // cycle. Not gated by state so a read accepted on the final TEST cycle
  // still returns after ownership has moved back to the core.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdValid_q <= 1'b0;
      rdData_q  <= '0;
    end else begin
      rdValid_q <= rdAccept;
      if (rdAccept) begin
        rdData_q <= rf_rdataA;
      end
    end
  end

`ifdef REGFILE_ARB_R0_PROTECT_EN
  // Error pulse for a rejected r0 write, aligned like a read response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= r0Hit;
    end
  end

  assign tst.tst_err = err_q;
`endif

  assign tst.tst_gnt    = gnt_q;
  assign tst.tst_ready  = tstReady;
  assign tst.tst_rvalid = rdValid_q;
  assign tst.tst_rdata  = rdData_q;

  assign core_stall  = stall_q;
  assign core_rdataA = rf_rdataA;
  assign core_rdataB = rf_rdataB;

  // The test side never holds the port without the core being stalled, and
  // the grant flag always tracks the TEST state.
  gntImpliesStall : assert property (
    @(posedge clock) disable iff (!reset) tst.tst_gnt |-> core_stall
  );

  gntTracksState : assert property (
    @(posedge clock) disable iff (!reset) (state_q == TEST) == tst.tst_gnt
  );

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_port_arbiter
//
// Self-checking bench for regfile_port_arbiter. A simple 32-entry regfile
// with hardwired r0 sits on the rf_* port; refMem is the bench's own view of
// what every register should hold, updated from the ownership rules.
// Optional feature macro exercised: REGFILE_ARB_R0_PROTECT_EN
// ---------------------------------------------------------------------------
module tb_regfile_port_arbiter;

`ifdef REGFILE_ARB_R0_PROTECT_EN
  localparam bit PROTECT = 1'b1;
`else
  localparam bit PROTECT = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        coreWe;
  logic [4:0]  coreWreg;
  logic [31:0] coreWdata;
  logic [4:0]  coreRregA;
  logic [4:0]  coreRregB;
  logic [31:0] coreRdataA;
  logic [31:0] coreRdataB;
  logic        coreStall;
  logic        rfWe;
  logic [4:0]  rfWreg;
  logic [31:0] rfWdata;
  logic [4:0]  rfRregA;
  logic [4:0]  rfRregB;
  logic [31:0] rfRdataA;
  logic [31:0] rfRdataB;

  logic [31:0] envRf [32] = '{default: 32'h0};
  logic [31:0] refMem [32] = '{default: 32'h0};

  int checks = 0;
  int failures = 0;

  regfile_port_arbiter_if #(.ADDR_W(5), .DATA_W(32)) tstIf ();

  regfile_port_arbiter #(.ADDR_W(5), .DATA_W(32), .DRAIN_CYCLES(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .core_we    (coreWe),
    .core_wreg  (coreWreg),
    .core_wdata (coreWdata),
    .core_rregA (coreRregA),
    .core_rregB (coreRregB),
    .core_rdataA(coreRdataA),
    .core_rdataB(coreRdataB),
    .core_stall (coreStall),
    .tst        (tstIf),
    .rf_we      (rfWe),
    .rf_wreg    (rfWreg),
    .rf_wdata   (rfWdata),
    .rf_rregA   (rfRregA),
    .rf_rregB   (rfRregB),
    .rf_rdataA  (rfRdataA),
    .rf_rdataB  (rfRdataB)
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Environment regfile with r0 hardwired to zero.
  always @(posedge clock) begin
    if (rfWe && rfWreg != 5'd0) envRf[rfWreg] <= rfWdata;
  end
  assign rfRdataA = envRf[rfRregA];
  assign rfRdataB = envRf[rfRregB];

  // Watchdog so a stuck run still terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic req, input logic valid, input logic we,
                               input logic [4:0] regIdx, input logic [31:0] wdata);
    tstIf.tst_req   = req;
    tstIf.tst_valid = valid;
    tstIf.tst_we    = we;
    tstIf.tst_reg   = regIdx;
    tstIf.tst_wdata = wdata;
  endtask

  task automatic applyCore(input logic we, input logic [4:0] wreg, input logic [31:0] wdata);
    coreWe    = we;
    coreWreg  = wreg;
    coreWdata = wdata;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  // Request ownership and wait, bounded, for the grant.
  task automatic enterTest();
    int budget;
    applyCore(1'b0, 5'd0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    budget = 0;
    while (tstIf.tst_gnt !== 1'b1 && budget < 20) begin
      nextCycle();
      budget++;
    end
    checks++; if (tstIf.tst_gnt !== 1'b1) begin failures++; $display("[TB] FAIL enter_gnt_timeout actual=%0b expected=1", tstIf.tst_gnt); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    coreRregA = 5'd0;
    coreRregB = 5'd0;
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    applyCore(1'b1, 5'd3, 32'hA5);
    refMem[3] = 32'hA5;
    #12;
    checks++; if (tstIf.tst_gnt !== 1'b0) begin failures++; $display("[TB] FAIL reset_gnt actual=%0h expected=0", tstIf.tst_gnt); end
    checks++; if (coreStall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall actual=%0h expected=0", coreStall); end
    checks++; if (tstIf.tst_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rvalid actual=%0h expected=0", tstIf.tst_rvalid); end
    checks++; if (tstIf.tst_rdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_rdata actual=%0h expected=0", tstIf.tst_rdata); end
    checks++; if (tstIf.tst_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready actual=%0h expected=0", tstIf.tst_ready); end
`ifdef REGFILE_ARB_R0_PROTECT_EN
    checks++; if (tstIf.tst_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err actual=%0h expected=0", tstIf.tst_err); end
`endif
    #6 reset = 1'b1;
    nextCycle();
    coreRregA = 5'd3;
    coreRregB = 5'd7;
    #1;
    checks++; if (rfWe !== 1'b1) begin failures++; $display("[TB] FAIL idle_rf_we actual=%0h expected=1", rfWe); end
    checks++; if (rfWreg !== 5'd3) begin failures++; $display("[TB] FAIL idle_rf_wreg actual=%0h expected=3", rfWreg); end
    checks++; if (rfWdata !== 32'hA5) begin failures++; $display("[TB] FAIL idle_rf_wdata actual=%0h expected=a5", rfWdata); end
    checks++; if (coreStall !== 1'b0) begin failures++; $display("[TB] FAIL idle_stall actual=%0h expected=0", coreStall); end
    checks++; if (tstIf.tst_gnt !== 1'b0) begin failures++; $display("[TB] FAIL idle_gnt actual=%0h expected=0", tstIf.tst_gnt); end
    checks++; if (coreRdataA !== refMem[3]) begin failures++; $display("[TB] FAIL idle_rdataA actual=%0h expected=%0h", coreRdataA, refMem[3]); end
    checks++; if (rfRregB !== 5'd7) begin failures++; $display("[TB] FAIL idle_rregB actual=%0h expected=7", rfRregB); end
    nextCycle();
    applyCore(1'b1, 5'd2, 32'h1234);
    #1;
    checks++; if (rfWe !== 1'b1 || rfWreg !== 5'd2) begin failures++; $display("[TB] FAIL idle_r2_write actual=%0h/%0h expected=1/2", rfWe, rfWreg); end
    refMem[2] = 32'h1234;
    nextCycle();
    applyCore(1'b0, 5'd0, 32'h0);
  endtask

  // Random core traffic while the core owns the port.
  task automatic test_core_passthrough();
    logic        we;
    logic [4:0]  wr;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] wd;
    for (int i = 0; i < 12; i++) begin
      we = 1'($urandom_range(0, 1));
      wr = 5'($urandom_range(8, 31));
      wd = $urandom;
      ra = 5'($urandom_range(0, 31));
      rb = 5'($urandom_range(0, 31));
      applyCore(we, wr, wd);
      coreRregA = ra;
      coreRregB = rb;
      #1;
      checks++; if (rfWe !== we) begin failures++; $display("[TB] FAIL pass_rf_we actual=%0h expected=%0h", rfWe, we); end
      if (we) begin
        checks++; if (rfWreg !== wr || rfWdata !== wd) begin failures++; $display("[TB] FAIL pass_rf_wr actual=%0h:%0h expected=%0h:%0h", rfWreg, rfWdata, wr, wd); end
      end
      checks++; if (coreRdataA !== refMem[ra]) begin failures++; $display("[TB] FAIL pass_rdataA actual=%0h expected=%0h", coreRdataA, refMem[ra]); end
      checks++; if (coreRdataB !== refMem[rb]) begin failures++; $display("[TB] FAIL pass_rdataB actual=%0h expected=%0h", coreRdataB, refMem[rb]); end
      checks++; if (coreStall !== 1'b0) begin failures++; $display("[TB] FAIL pass_stall actual=%0h expected=0", coreStall); end
      if (we && wr != 5'd0) refMem[wr] = wd;
      nextCycle();
    end
    applyCore(1'b0, 5'd0, 32'h0);
    coreRregA = 5'd0;
    coreRregB = 5'd0;
  endtask

  // Request at cycle N: stall from N+1, core write at N+2 retires, grant at N+5.
  task automatic test_drain();
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    checks++; if (coreStall !== 1'b0) begin failures++; $display("[TB] FAIL drain_n_stall actual=%0h expected=0", coreStall); end
    for (int k = 1; k <= 4; k++) begin
      nextCycle();
      if (k == 2) begin
        applyCore(1'b1, 5'd5, 32'd7);
        applyStimulus(1'b1, 1'b1, 1'b1, 5'd6, 32'hDEAD);
      end else begin
        applyCore(1'b0, 5'd0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      end
      #1;
      checks++; if (coreStall !== 1'b1) begin failures++; $display("[TB] FAIL drain_stall cycle=%0d actual=%0h expected=1", k, coreStall); end
      checks++; if (tstIf.tst_gnt !== 1'b0) begin failures++; $display("[TB] FAIL drain_gnt cycle=%0d actual=%0h expected=0", k, tstIf.tst_gnt); end
      checks++; if (tstIf.tst_ready !== 1'b0) begin failures++; $display("[TB] FAIL drain_ready cycle=%0d actual=%0h expected=0", k, tstIf.tst_ready); end
      if (k == 2) begin
        checks++; if (rfWe !== 1'b1 || rfWreg !== 5'd5 || rfWdata !== 32'd7) begin failures++; $display("[TB] FAIL drain_core_wb actual=%0h/%0h/%0h expected=1/5/7", rfWe, rfWreg, rfWdata); end
        refMem[5] = 32'd7;
      end
    end
    nextCycle();
    applyCore(1'b0, 5'd0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    checks++; if (tstIf.tst_gnt !== 1'b1) begin failures++; $display("[TB] FAIL drain_gnt_n5 actual=%0h expected=1", tstIf.tst_gnt); end
    checks++; if (coreStall !== 1'b1) begin failures++; $display("[TB] FAIL test_stall actual=%0h expected=1", coreStall); end
    checks++; if (tstIf.tst_ready !== 1'b1) begin failures++; $display("[TB] FAIL test_ready actual=%0h expected=1", tstIf.tst_ready); end
    checks++; if (tstIf.tst_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL drain_no_resp actual=%0h expected=0", tstIf.tst_rvalid); end
  endtask

  task automatic test_write_read();
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd1, 32'd65535);
    #1;
    checks++; if (rfWe !== 1'b1 || rfWreg !== 5'd1 || rfWdata !== 32'd65535) begin failures++; $display("[TB] FAIL wr_r1 actual=%0h/%0h/%0h expected=1/1/ffff", rfWe, rfWreg, rfWdata); end
    refMem[1] = 32'd65535;
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd1, 32'h0);
    #1;
    checks++; if (rfWe !== 1'b0 || rfRregA !== 5'd1) begin failures++; $display("[TB] FAIL rd_r1_issue actual=%0h/%0h expected=0/1", rfWe, rfRregA); end
    checks++; if (tstIf.tst_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL rd_r1_early actual=%0h expected=0", tstIf.tst_rvalid); end
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd5, 32'h0);
    #1;
    checks++; if (tstIf.tst_rvalid !== 1'b1 || tstIf.tst_rdata !== 32'd65535) begin failures++; $display("[TB] FAIL rd_r1_resp actual=%0h/%0h expected=1/ffff", tstIf.tst_rvalid, tstIf.tst_rdata); end
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd3, 32'h0);
    #1;
    checks++; if (tstIf.tst_rvalid !== 1'b1 || tstIf.tst_rdata !== refMem[5]) begin failures++; $display("[TB] FAIL rd_r5_resp actual=%0h/%0h expected=1/%0h", tstIf.tst_rvalid, tstIf.tst_rdata, refMem[5]); end
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    checks++; if (tstIf.tst_rvalid !== 1'b1 || tstIf.tst_rdata !== refMem[3]) begin failures++; $display("[TB] FAIL rd_r3_resp actual=%0h/%0h expected=1/%0h", tstIf.tst_rvalid, tstIf.tst_rdata, refMem[3]); end
    nextCycle();
    #1;
    checks++; if (tstIf.tst_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL rd_pulse_end actual=%0h expected=0", tstIf.tst_rvalid); end
  endtask

  task automatic test_core_lockout();
    applyCore(1'b1, 5'd2, 32'd9);
    #1;
    checks++; if (rfWe !== 1'b0) begin failures++; $display("[TB] FAIL lockout_rf_we actual=%0h expected=0", rfWe); end
    nextCycle();
    applyCore(1'b0, 5'd0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd2, 32'h0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    checks++; if (tstIf.tst_rvalid !== 1'b1 || tstIf.tst_rdata !== refMem[2]) begin failures++; $display("[TB] FAIL lockout_r2 actual=%0h/%0h expected=1/%0h", tstIf.tst_rvalid, tstIf.tst_rdata, refMem[2]); end
  endtask

  // Random back-to-back test ops, with random core writes that must be ignored.
  task automatic test_random_ops();
    logic        v;
    logic        w;
    logic [4:0]  r;
    logic [31:0] d;
    logic [4:0]  rb;
    logic        pendValid;
    logic [31:0] pendData;
    logic        pendErr;
    logic        expWe;
    pendValid = 1'b0;
    pendData  = 32'h0;
    pendErr   = 1'b0;
    nextCycle();
    for (int i = 0; i < 80; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      w  = 1'($urandom_range(0, 1));
      r  = 5'($urandom_range(0, 31));
      d  = $urandom;
      rb = 5'($urandom_range(0, 31));
      applyCore(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      coreRregB = rb;
      applyStimulus(1'b1, v, w, r, d);
      #1;
      checks++; if (tstIf.tst_rvalid !== pendValid) begin failures++; $display("[TB] FAIL rnd_rvalid i=%0d actual=%0h expected=%0h", i, tstIf.tst_rvalid, pendValid); end
      if (pendValid) begin
        checks++; if (tstIf.tst_rdata !== pendData) begin failures++; $display("[TB] FAIL rnd_rdata i=%0d actual=%0h expected=%0h", i, tstIf.tst_rdata, pendData); end
      end
`ifdef REGFILE_ARB_R0_PROTECT_EN
      checks++; if (tstIf.tst_err !== pendErr) begin failures++; $display("[TB] FAIL rnd_err i=%0d actual=%0h expected=%0h", i, tstIf.tst_err, pendErr); end
`endif
      expWe = v && w && (!PROTECT || r != 5'd0);
      checks++; if (rfWe !== expWe) begin failures++; $display("[TB] FAIL rnd_rf_we i=%0d actual=%0h expected=%0h", i, rfWe, expWe); end
      if (expWe) begin
        checks++; if (rfWreg !== r || rfWdata !== d) begin failures++; $display("[TB] FAIL rnd_rf_wr i=%0d actual=%0h:%0h expected=%0h:%0h", i, rfWreg, rfWdata, r, d); end
      end
      if (v && !w) begin
        checks++; if (rfRregA !== r) begin failures++; $display("[TB] FAIL rnd_rregA i=%0d actual=%0h expected=%0h", i, rfRregA, r); end
      end
      checks++; if (rfRregB !== rb) begin failures++; $display("[TB] FAIL rnd_rregB i=%0d actual=%0h expected=%0h", i, rfRregB, rb); end
      checks++; if (tstIf.tst_ready !== 1'b1) begin failures++; $display("[TB] FAIL rnd_ready i=%0d actual=%0h expected=1", i, tstIf.tst_ready); end
      pendValid = v && !w;
      pendData  = refMem[r];
      pendErr   = PROTECT && v && w && (r == 5'd0);
      if (v && w && r != 5'd0) refMem[r] = d;
      nextCycle();
    end
    applyCore(1'b0, 5'd0, 32'h0);
    coreRregB = 5'd0;
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    nextCycle();
  endtask

  // Read on the last TEST cycle, then drop the request.
  task automatic test_release();
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd1, 32'h0);
    #1;
    checks++; if (tstIf.tst_ready !== 1'b1) begin failures++; $display("[TB] FAIL rel_ready_last actual=%0h expected=1", tstIf.tst_ready); end
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 5'd7, 32'hBAD);
    #1;
    checks++; if (tstIf.tst_ready !== 1'b0 || rfWe !== 1'b0) begin failures++; $display("[TB] FAIL rel_refuse actual=%0h/%0h expected=0/0", tstIf.tst_ready, rfWe); end
    checks++; if (tstIf.tst_rvalid !== 1'b1 || tstIf.tst_rdata !== refMem[1]) begin failures++; $display("[TB] FAIL rel_last_read actual=%0h/%0h expected=1/%0h", tstIf.tst_rvalid, tstIf.tst_rdata, refMem[1]); end
    checks++; if (tstIf.tst_gnt !== 1'b1) begin failures++; $display("[TB] FAIL rel_gnt_hold actual=%0h expected=1", tstIf.tst_gnt); end
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    applyCore(1'b1, 5'd4, 32'h44);
    #1;
    checks++; if (tstIf.tst_gnt !== 1'b0 || coreStall !== 1'b0) begin failures++; $display("[TB] FAIL rel_core_back actual=%0h/%0h expected=0/0", tstIf.tst_gnt, coreStall); end
    checks++; if (rfWe !== 1'b1 || rfWreg !== 5'd4) begin failures++; $display("[TB] FAIL rel_core_write actual=%0h/%0h expected=1/4", rfWe, rfWreg); end
    checks++; if (tstIf.tst_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL rel_rvalid actual=%0h expected=0", tstIf.tst_rvalid); end
    refMem[4] = 32'h44;
    nextCycle();
    applyCore(1'b0, 5'd0, 32'h0);
  endtask

  // Drop the request in the drain cycle where the counter holds 2.
  task automatic test_abort();
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    nextCycle();
    nextCycle();
    checks++; if (coreStall !== 1'b1 || tstIf.tst_gnt !== 1'b0) begin failures++; $display("[TB] FAIL abort_drain actual=%0h/%0h expected=1/0", coreStall, tstIf.tst_gnt); end
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    checks++; if (coreStall !== 1'b1 || tstIf.tst_gnt !== 1'b0) begin failures++; $display("[TB] FAIL abort_cnt2 actual=%0h/%0h expected=1/0", coreStall, tstIf.tst_gnt); end
    for (int k = 0; k < 4; k++) begin
      nextCycle();
      checks++; if (coreStall !== 1'b0 || tstIf.tst_gnt !== 1'b0) begin failures++; $display("[TB] FAIL abort_core k=%0d actual=%0h/%0h expected=0/0", k, coreStall, tstIf.tst_gnt); end
    end
  endtask

  // Reset pulse strictly between clock edges while a read response is out.
  task automatic test_async_reset();
    enterTest();
    applyStimulus(1'b1, 1'b1, 1'b0, 5'd1, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    checks++; if (tstIf.tst_rvalid !== 1'b1 || tstIf.tst_rdata !== refMem[1]) begin failures++; $display("[TB] FAIL ares_pre actual=%0h/%0h expected=1/%0h", tstIf.tst_rvalid, tstIf.tst_rdata, refMem[1]); end
    #2 reset = 1'b0;
    #1;
    checks++; if (tstIf.tst_gnt !== 1'b0 || coreStall !== 1'b0) begin failures++; $display("[TB] FAIL ares_gnt_stall actual=%0h/%0h expected=0/0", tstIf.tst_gnt, coreStall); end
    checks++; if (tstIf.tst_rvalid !== 1'b0 || tstIf.tst_rdata !== 32'h0) begin failures++; $display("[TB] FAIL ares_resp actual=%0h/%0h expected=0/0", tstIf.tst_rvalid, tstIf.tst_rdata); end
    #3 reset = 1'b1;
    nextCycle();
    checks++; if (coreStall !== 1'b0 || tstIf.tst_gnt !== 1'b0) begin failures++; $display("[TB] FAIL ares_after actual=%0h/%0h expected=0/0", coreStall, tstIf.tst_gnt); end
  endtask

  task automatic test_r0_write();
    enterTest();
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd0, 32'h5A5A);
    #1;
    checks++; if (tstIf.tst_ready !== 1'b1) begin failures++; $display("[TB] FAIL r0_ready actual=%0h expected=1", tstIf.tst_ready); end
    checks++; if (rfWe !== !PROTECT) begin failures++; $display("[TB] FAIL r0_rf_we actual=%0h expected=%0h", rfWe, !PROTECT); end
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
`ifdef REGFILE_ARB_R0_PROTECT_EN
    #1;
    checks++; if (tstIf.tst_err !== 1'b1) begin failures++; $display("[TB] FAIL r0_err_pulse actual=%0h expected=1", tstIf.tst_err); end
    nextCycle();
    checks++; if (tstIf.tst_err !== 1'b0) begin failures++; $display("[TB] FAIL r0_err_end actual=%0h expected=0", tstIf.tst_err); end
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    nextCycle();
  endtask

  initial begin
    test_reset();
    test_core_passthrough();
    test_drain();
    test_write_read();
    test_core_lockout();
    test_random_ops();
    test_release();
    test_abort();
    test_async_reset();
    test_r0_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
